// File: rtl/uart_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_checker
//
// Checks one UART receive frame bit by bit, as the RX data sampler delivers
// mid-bit samples. It covers the start-bit glitch, LSB-first data
// deserialisation, the optional parity bit and one or two stop bits. It also
// keeps a saturating counter for each error type.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..16)
//   CNT_WIDTH   width of each saturating error counter
//
// Ports:
//   CLK, RST_n       clock (rising edge), asynchronous active-low reset
//   frm_start        arms the checker; the next bit_valid is the start bit
//   bit_valid        sampled_bit is valid this cycle
//   sampled_bit      majority-voted line sample
//   PAR_EN/PAR_TYP   parity present / odd parity (latched on frm_start)
//   STOP_2           two stop bits (latched on frm_start)
//   clr_cnt          synchronous clear of all error counters
//   busy             checker is inside a frame
//   strt_glitch      start bit sampled high in the last armed frame
//   par_err/stp_err  parity / stop-bit error in the last frame
//   frame_done       1-cycle pulse when a frame completes
//   frame_ok         with frame_done: neither parity nor stop error
//   P_DATA           received data, updated only with frame_done
//   *_cnt            saturating error counters
// -----------------------------------------------------------------------------
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  frm_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP_2,
  input  logic                  clr_cnt,
  output logic                  busy,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic [CNT_WIDTH-1:0]  glitch_cnt,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int                IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [IDX_W-1:0]        bit_idx;
  logic                    stop_idx;
  logic                    par_acc;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    stop2_q;

  // A strobe only counts when frm_start is not present in the same cycle.
  logic bit_take;
  logic glitch_hit;
  logic last_stop;
  logic inc_par;
  logic inc_stp;

  assign bit_take   = bit_valid && !frm_start;
  assign glitch_hit = bit_take && (state == ST_START) && sampled_bit;
  assign last_stop  = bit_take && (state == ST_STOP) && !(stop2_q && !stop_idx);
  assign inc_par    = last_stop && par_err;
  // The stop error of the frame includes the final stop bit being sampled now,
  // so a frame with both stop bits low still counts once.
  assign inc_stp    = last_stop && (stp_err || !sampled_bit);

  assign busy = (state != ST_IDLE);

  // NOTE: every register here is assigned with <= so that all of them see the
  // pre-edge values of each other; blocking assignments would make the result
  // depend on statement order.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      par_acc     <= 1'b0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      P_DATA      <= '0;
      glitch_cnt  <= '0;
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;

      if (frm_start) begin
        // Re-arm from any state; an unfinished frame is dropped silently.
        state       <= ST_START;
        strt_glitch <= 1'b0;
        par_err     <= 1'b0;
        stp_err     <= 1'b0;
        par_en_q    <= PAR_EN;
        par_typ_q   <= PAR_TYP;
        stop2_q     <= STOP_2;
      end else if (bit_valid) begin
        case (state)
          ST_START: begin
            if (sampled_bit) begin
              strt_glitch <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
              par_acc <= 1'b0;
            end
          end
          ST_DATA: begin
            // Shift right from the MSB: the first data bit lands in bit 0.
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            par_acc   <= par_acc ^ sampled_bit;
            if (bit_idx == LAST_IDX) begin
              state    <= par_en_q ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          ST_PARITY: begin
            if (sampled_bit != (par_acc ^ par_typ_q)) par_err <= 1'b1;
            state    <= ST_STOP;
            stop_idx <= 1'b0;
          end
          ST_STOP: begin
            if (!sampled_bit) stp_err <= 1'b1;
            if (stop2_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state      <= ST_IDLE;
              frame_done <= 1'b1;
              frame_ok   <= !par_err && !stp_err && sampled_bit;
              P_DATA     <= shift_reg;
            end
          end
          default: ;
        endcase
      end

      // Counter clear takes priority over a coincident increment.
      if (clr_cnt) begin
        glitch_cnt  <= '0;
        par_err_cnt <= '0;
        stp_err_cnt <= '0;
      end else begin
        if (glitch_hit && glitch_cnt != CNT_MAX) glitch_cnt  <= glitch_cnt + 1'b1;
        if (inc_par && par_err_cnt != CNT_MAX)   par_err_cnt <= par_err_cnt + 1'b1;
        if (inc_stp && stp_err_cnt != CNT_MAX)   stp_err_cnt <= stp_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
Parametrised successor to the UART RX start-bit checker. It covers the whole receive frame: start-bit glitch, data deserialisation, parity and stop-bit checks. Configurable data width, parity mode and stop-bit count, with saturating per-error-type counters. It sits between the RX data sampler, which supplies one mid-bit sample per bit_valid strobe, and the RX FSM/register file.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..16), LSB first on the line
CNT_WIDTH, 8, width of each saturating error counter

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_n  in  1  asynchronous active-low reset
frm_start  in  1  1-cycle pulse from RX FSM; arms checker; next bit_valid is the start bit
bit_valid  in  1  1-cycle strobe; sampled_bit is valid this cycle
sampled_bit  in  1  majority-voted line sample
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
STOP_2  in  1  1 = two stop bits
clr_cnt  in  1  synchronous clear of all error counters
busy  out  1  high while state != IDLE
strt_glitch  out  1  start bit sampled high in last armed frame
par_err  out  1  parity mismatch in last frame
stp_err  out  1  any stop bit sampled low in last frame
frame_done  out  1  1-cycle pulse; frame completed (not on glitch abort)
frame_ok  out  1  valid with frame_done; high iff par_err=0 and stp_err=0
P_DATA  out  DATA_WIDTH  received data, updated only with frame_done
glitch_cnt, par_err_cnt, stp_err_cnt  out  CNT_WIDTH each  saturating error counters

Behaviour:
- Reset: state IDLE; all outputs 0, including P_DATA and counters; internal shift register, bit index and parity accumulator cleared.
- PAR_EN, PAR_TYP and STOP_2 are latched on frm_start. Changes mid-frame are ignored.
- frm_start in any state: clear strt_glitch, par_err and stp_err, go to START. An in-progress frame is aborted silently: no frame_done, no counter change.
- frm_start and bit_valid in the same cycle: frm_start wins and the bit is discarded.
- bit_valid in IDLE is ignored.
- START, on bit_valid:
  - sampled_bit=1: strt_glitch<=1, glitch_cnt++, go to IDLE, no frame_done.
  - sampled_bit=0: go to DATA, bit_idx=0, parity accumulator=0.
- DATA, on bit_valid:
  - shift sampled_bit into the MSB, shifting right, so bit 0 = first data bit after DATA_WIDTH shifts.
  - accumulator ^= sampled_bit.
  - at bit_idx=DATA_WIDTH-1: go to PARITY if latched PAR_EN, else STOP. Otherwise bit_idx++.
- PARITY, on bit_valid: expected = accumulator ^ PAR_TYP. Mismatch sets par_err<=1. Go to STOP with stop_idx=0.
- STOP, on bit_valid:
  - sampled_bit=0 sets stp_err<=1.
  - if latched STOP_2 and stop_idx=0: stop_idx=1, stay in STOP.
  - otherwise: go to IDLE; frame_done=1 and P_DATA<=shift register in the next cycle.
- Flag latency: every flag and counter updates on the clock edge ending the bit_valid cycle, so it is visible 1 cycle later.
- frame_done: asserts 1 cycle after the final stop-bit bit_valid, for exactly 1 cycle. frame_ok is valid in the same cycle.
- Error flags: hold until the next frm_start or reset.
- par_err_cnt: +1 per frame with par_err.
- stp_err_cnt: +1 per frame with stp_err, once even if both stop bits are low. Both counters increment in the frame_done cycle.
- Counters saturate at 2^CNT_WIDTH-1 with no wrap.
- clr_cnt coincident with an increment: clear wins, counter = 0.
- Reset mid-frame: immediate return to the reset state; the frame is lost.

Test Plan:
1. DATA_WIDTH=8, PAR_EN=0, STOP_2=0; frame 0,0xA5 LSB first,1 -> frame_done 1 cycle after stop strobe, P_DATA=0xA5, frame_ok=1, all counters 0.
2. Start bit sampled 1 after frm_start -> strt_glitch=1, glitch_cnt=1, busy=0, no frame_done; next frm_start clears strt_glitch.
3. PAR_EN=1: PAR_TYP=0 with data 0x03 and parity 1 -> par_err=1, par_err_cnt=1, frame_ok=0. PAR_TYP=1 with data 0x03 and parity 1 -> par_err=0.
4. STOP_2=1, stop bits 1 then 0 -> stp_err=1, stp_err_cnt +1. Stop bits 0,0 -> stp_err_cnt +1 only. frame_done only after the second stop strobe.
5. CNT_WIDTH=2, 5 glitch frames -> glitch_cnt=3. clr_cnt together with a 6th glitch -> glitch_cnt=0.
6. frm_start mid-DATA (after 4 bits), then a full 0x3C frame -> single frame_done, P_DATA=0x3C. RST_n low mid-frame -> all outputs 0 immediately.
